seg7_shift_ctrl: RTL and testbench

SEG7_SHIFT_CTRL -- requirements
Module: seg7_shift_ctrl

---
 rtl/seg7_shift_ctrl.sv | 138 +++++++++++++
 tb/tb_seg7_shift_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_shift_ctrl.sv
// Serialises one segment frame into an external shift-register chain and
// pulses the storage latch; back-to-back requests are queued as one pending frame.
module seg7_shift_ctrl #(
    parameter int DIV   = 2,
    parameter int NBITS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] seg_data,
    output logic             seg_clk,
    output logic             seg_dout,
    output logic             seg_latch,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int            BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    state_t           state, state_nxt;
    logic [NBITS-1:0] shreg, shreg_nxt, shreg_sh;
    logic [7:0]       div_cnt, div_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic             clk_nxt, dout_nxt, latch_nxt, busy_nxt, done_nxt;
    logic             pending, pend_nxt;
    logic             load;

    assign shreg_sh  = shreg << 1;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            seg_clk   <= 1'b0;
            seg_dout  <= 1'b0;
            seg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pending   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            seg_clk   <= clk_nxt;
            seg_dout  <= dout_nxt;
            seg_latch <= latch_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pending   <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        clk_nxt   = seg_clk;
        dout_nxt  = seg_dout;
        latch_nxt = 1'b0;
        done_nxt  = 1'b0;
        pend_nxt  = pending;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (start) load = 1'b1;
            end
            SHIFT: begin
                if (start) pend_nxt = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (!seg_clk) begin
                        clk_nxt = 1'b1;
                    end else begin
                        // End of a high phase: the only point where data may move.
                        clk_nxt = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = LATCH;
                            latch_nxt = 1'b1;
                        end else begin
                            shreg_nxt = shreg_sh;
                            dout_nxt  = shreg_sh[NBITS-1];
                            bit_nxt   = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            LATCH: begin
                if (start) pend_nxt = 1'b1;
                latch_nxt = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    div_nxt   = '0;
                    latch_nxt = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            DONE: begin
                if (pending || start) load = 1'b1;
                else state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // A new frame always starts from a clean low phase on bit 0.
        if (load) begin
            state_nxt = SHIFT;
            shreg_nxt = seg_data;
            dout_nxt  = seg_data[NBITS-1];
            clk_nxt   = 1'b0;
            div_nxt   = '0;
            bit_nxt   = '0;
            pend_nxt  = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_seg7_shift_ctrl.sv
// Directed bench for seg7_shift_ctrl: a DIV=2 and a DIV=1 instance share
// clock, reset and data; sel routes start to one of them and muxes its outputs.
module tb_seg7_shift_ctrl;

    typedef struct {
        string       name;
        logic        sel;
        logic [63:0] data;
        int          chg_at;
        logic [63:0] chg_data;
        int          p1, p2, p3;
        int          exp_busy, exp_rise, exp_latch, exp_done;
        int          nfr;
        logic [63:0] f0, f1;
        logic        exp_dout_end;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [63:0] seg_data = '0;

    logic start_a, start_b;
    logic clk_a, dout_a, latch_a, busy_a, done_a;
    logic clk_b, dout_b, latch_b, busy_b, done_b;
    logic [1:0] st_a, st_b;
    logic m_clk, m_dout, m_latch, m_busy, m_done;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign m_clk   = sel ? clk_b   : clk_a;
    assign m_dout  = sel ? dout_b  : dout_a;
    assign m_latch = sel ? latch_b : latch_a;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;

    seg7_shift_ctrl #(.DIV(2), .NBITS(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seg_data(seg_data),
        .seg_clk(clk_a), .seg_dout(dout_a), .seg_latch(latch_a),
        .busy(busy_a), .done(done_a), .state_dbg(st_a)
    );

    seg7_shift_ctrl #(.DIV(1), .NBITS(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seg_data(seg_data),
        .seg_clk(clk_b), .seg_dout(dout_b), .seg_latch(latch_b),
        .busy(busy_b), .done(done_b), .state_dbg(st_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic s, input logic [63:0] d,
                                input int chg_at, input logic [63:0] chg_d,
                                input int p1, input int p2, input int p3,
                                input int eb, input int er, input int el, input int ed,
                                input int nfr, input logic [63:0] f0, input logic [63:0] f1,
                                input logic de);
        vec_t v;
        v.name = name; v.sel = s; v.data = d; v.chg_at = chg_at; v.chg_data = chg_d;
        v.p1 = p1; v.p2 = p2; v.p3 = p3;
        v.exp_busy = eb; v.exp_rise = er; v.exp_latch = el; v.exp_done = ed;
        v.nfr = nfr; v.f0 = f0; v.f1 = f1; v.exp_dout_end = de;
        return v;
    endfunction

    // Follows the selected DUT while busy; one expected frame word is popped per 64 rises.
    task automatic verify_vec(input vec_t v);
        int   n_busy, n_rise, n_latch, n_done, nb;
        logic prev_clk;
        logic [63:0] word, exp_w;
        n_busy = 0; n_rise = 0; n_latch = 0; n_done = 0; nb = 0;
        prev_clk = 1'b0; word = '0;
        exp_q.delete();
        exp_q.push_back(v.f0);
        if (v.nfr == 2) exp_q.push_back(v.f1);
        while (m_busy === 1'b1 && n_busy < 2000) begin
            n_busy++;
            if (m_latch) n_latch++;
            if (m_done) n_done++;
            if (m_clk && !prev_clk) begin
                word = {word[62:0], m_dout};
                n_rise++;
                nb++;
                if (nb == 64) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        check_int({v.name, " extra_frame"}, 1, 0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check({v.name, " frame_bits"}, word, exp_w);
                    end
                end
            end
            prev_clk = m_clk;
            start = (n_busy == v.p1) || (n_busy == v.p2) || (n_busy == v.p3);
            if (n_busy == v.chg_at) seg_data = v.chg_data;
            tick();
        end
        start = 1'b0;
        check_int({v.name, " busy_cycles"}, n_busy, v.exp_busy);
        check_int({v.name, " clk_rises"}, n_rise, v.exp_rise);
        check_int({v.name, " latch_cycles"}, n_latch, v.exp_latch);
        check_int({v.name, " done_pulses"}, n_done, v.exp_done);
        check_int({v.name, " frames_left"}, exp_q.size(), 0);
        check({v.name, " idle_seg_clk"}, {63'd0, m_clk}, 64'd0);
        check({v.name, " idle_latch"}, {63'd0, m_latch}, 64'd0);
        check({v.name, " idle_dout_hold"}, {63'd0, m_dout}, {63'd0, v.exp_dout_end});
    endtask

    task automatic run_vec(input vec_t v);
        sel = v.sel;
        seg_data = v.data;
        start = 1'b1;
        tick();
        start = 1'b0;
        verify_vec(v);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat_cnt, drops, ndone, first_d, last_d, waited;
        vec_t rv;

        vecs[0] = mk("v_msb_lsb", 0, 64'h8000_0000_0000_0001, 0, '0, 0, 0, 0,
                     259, 64, 2, 1, 1, 64'h8000_0000_0000_0001, '0, 1'b1);
        vecs[1] = mk("v_count", 0, 64'h0123_4567_89AB_CDEF, 0, '0, 0, 0, 0,
                     259, 64, 2, 1, 1, 64'h0123_4567_89AB_CDEF, '0, 1'b1);
        vecs[2] = mk("v_data_change", 0, 64'h0, 10, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
                     259, 64, 2, 1, 1, 64'h0, '0, 1'b0);
        vecs[3] = mk("v_mixed", 0, 64'hF00D_CAFE_1234_5678, 0, '0, 0, 0, 0,
                     259, 64, 2, 1, 1, 64'hF00D_CAFE_1234_5678, '0, 1'b0);
        vecs[4] = mk("v_pending", 0, 64'hDEAD_BEEF_0000_FFFF, 15, 64'h1234_5678_9ABC_DEF0,
                     20, 50, 200, 518, 128, 4, 2, 2,
                     64'hDEAD_BEEF_0000_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b0);
        vecs[5] = mk("v_div1_aa", 1, 64'hAAAA_AAAA_AAAA_AAAA, 0, '0, 0, 0, 0,
                     130, 64, 1, 1, 1, 64'hAAAA_AAAA_AAAA_AAAA, '0, 1'b0);
        vecs[6] = mk("v_div1_55", 1, 64'h5555_5555_5555_5555, 0, '0, 0, 0, 0,
                     130, 64, 1, 1, 1, 64'h5555_5555_5555_5555, '0, 1'b1);

        // Power-on reset: outputs must clear without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_seg_clk", {63'd0, clk_a}, 64'd0);
        check("rst_dout", {63'd0, dout_a}, 64'd0);
        check("rst_latch", {63'd0, latch_a}, 64'd0);
        check("rst_done", {63'd0, done_a}, 64'd0);
        check("rst_state", {62'd0, st_a}, 64'd0);
        check("rst_busy_div1", {63'd0, busy_b}, 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_no_start", {63'd0, busy_a}, 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted mid-frame (cycle 100) aborts without a latch pulse.
        sel = 1'b0;
        seg_data = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat_cnt = 0;
        for (int i = 1; i < 100; i++) begin
            if (latch_a) lat_cnt++;
            tick();
        end
        check("abort_busy_before", {63'd0, busy_a}, 64'd1);
        check("abort_dout_before", {63'd0, dout_a}, 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy_a}, 64'd0);
        check("abort_dout", {63'd0, dout_a}, 64'd0);
        check("abort_seg_clk", {63'd0, clk_a}, 64'd0);
        check("abort_state", {62'd0, st_a}, 64'd0);
        repeat (2) begin
            tick();
            if (latch_a) lat_cnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (latch_a) lat_cnt++;
        end
        check("abort_stays_idle", {63'd0, busy_a}, 64'd0);
        check_int("abort_latch_cycles", lat_cnt, 0);

        // start already high on the first edge after reset release.
        rst_n = 1'b0;
        seg_data = 64'hC3C3_0000_FFFF_0001;
        start = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        start = 1'b0;
        check("first_edge_busy", {63'd0, busy_a}, 64'd1);
        check("first_edge_state", {62'd0, st_a}, 64'd1);
        rv = mk("v_after_reset", 0, 64'hC3C3_0000_FFFF_0001, 0, '0, 0, 0, 0,
                259, 64, 2, 1, 1, 64'hC3C3_0000_FFFF_0001, '0, 1'b1);
        verify_vec(rv);
        repeat (3) tick();

        // start held high: busy never drops, one done per 259 cycles.
        seg_data = 64'h0F0F_0F0F_0F0F_0F0F;
        start = 1'b1;
        tick();
        drops = 0; ndone = 0; first_d = 0; last_d = 0;
        for (int k = 1; k <= 800; k++) begin
            if (!busy_a) drops++;
            if (done_a) begin
                ndone++;
                if (first_d == 0) first_d = k;
                last_d = k;
            end
            tick();
        end
        start = 1'b0;
        check_int("held_busy_drops", drops, 0);
        check_int("held_done_count", ndone, 3);
        check_int("held_first_done", first_d, 259);
        check_int("held_done_span", last_d - first_d, 518);
        waited = 0;
        while (busy_a && waited < 1200) begin
            waited++;
            tick();
        end
        check("held_ends_idle", {63'd0, busy_a}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
